// File: rtl/window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line buffers supply the upper rows; windows are flagged valid only fully in-frame.
module window_gen #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pix_in,
  input  logic       pix_valid,
  output logic [3:0] pixel1,
  output logic [3:0] pixel2,
  output logic [3:0] pixel3,
  output logic [3:0] pixel4,
  output logic [3:0] pixel5,
  output logic [3:0] pixel6,
  output logic [3:0] pixel7,
  output logic [3:0] pixel8,
  output logic [3:0] pixel9,
  output logic       win_valid,
  output logic       win_last
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [3:0]    lb0_r [IMG_WIDTH];
  logic [3:0]    lb1_r [IMG_WIDTH];
  logic [3:0]    win_r [9];
  logic          win_valid_r;
  logic          win_last_r;

  logic [3:0]    top_s;
  logic [3:0]    mid_s;
  logic          col_end_s;
  logic          row_end_s;
  logic          in_win_s;

  // Column taps from the line buffers and position decodes for the pixel being accepted
  always_comb begin
    top_s     = lb1_r[col_r];
    mid_s     = lb0_r[col_r];
    col_end_s = (col_r == CW'(IMG_WIDTH - 1));
    row_end_s = (row_r == RW'(IMG_HEIGHT - 1));
    in_win_s  = (row_r >= RW'(2)) && (col_r >= CW'(2));
  end

  // Line buffers are left uncleared: rows 0 and 1 of each frame overwrite them before use
  always_ff @(posedge clk) begin
    if (pix_valid && !rst) begin
      lb1_r[col_r] <= lb0_r[col_r];
      lb0_r[col_r] <= pix_in;
    end
  end

  // Raster position, window shift register and window flags
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r       <= '0;
      row_r       <= '0;
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= 4'd0;
      end
    end else begin
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
      if (pix_valid) begin
        if (col_end_s) begin
          col_r <= '0;
          row_r <= row_end_s ? '0 : row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
        win_r[0]    <= win_r[1];
        win_r[1]    <= win_r[2];
        win_r[2]    <= top_s;
        win_r[3]    <= win_r[4];
        win_r[4]    <= win_r[5];
        win_r[5]    <= mid_s;
        win_r[6]    <= win_r[7];
        win_r[7]    <= win_r[8];
        win_r[8]    <= pix_in;
        win_valid_r <= in_win_s;
        win_last_r  <= in_win_s && col_end_s && row_end_s;
      end
    end
  end

  assign pixel1    = win_r[0];
  assign pixel2    = win_r[1];
  assign pixel3    = win_r[2];
  assign pixel4    = win_r[3];
  assign pixel5    = win_r[4];
  assign pixel6    = win_r[5];
  assign pixel7    = win_r[6];
  assign pixel8    = win_r[7];
  assign pixel9    = win_r[8];
  assign win_valid = win_valid_r;
  assign win_last  = win_last_r;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen on a 4x4 frame: directed raster streams followed by random traffic,
// checked against a frame-image model that extracts each window by position.
module tb_window_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_valid;
  logic [3:0] pix_in;
  logic [3:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       win_valid;
  logic       win_last;
  logic [3:0] obs [9];

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  int         img [H][W];
  int         k;
  logic [3:0] exp_win [9];
  logic       exp_valid;
  logic       exp_last;
  logic       win_known;
  logic       p9_known;
  logic [3:0] last_pix;

  always #5 clk = ~clk;

  window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pixel1(p1), .pixel2(p2), .pixel3(p3), .pixel4(p4), .pixel5(p5),
    .pixel6(p6), .pixel7(p7), .pixel8(p8), .pixel9(p9),
    .win_valid(win_valid), .win_last(win_last)
  );

  assign obs[0] = p1;
  assign obs[1] = p2;
  assign obs[2] = p3;
  assign obs[3] = p4;
  assign obs[4] = p5;
  assign obs[5] = p6;
  assign obs[6] = p7;
  assign obs[7] = p8;
  assign obs[8] = p9;

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // One clock: drive inputs, advance the model, then sample 1 time unit after the edge
  task automatic step(input logic r, input logic v, input logic [3:0] p);
    int rr, cc;
    rst = r; pix_valid = v; pix_in = p;
    @(posedge clk);
    if (r) begin
      k = 0;
      exp_valid = 1'b0; exp_last = 1'b0;
      for (int i = 0; i < 9; i++) exp_win[i] = 4'd0;
      win_known = 1'b1; p9_known = 1'b1; last_pix = 4'd0;
    end else if (v) begin
      rr = k / W;
      cc = k % W;
      img[rr][cc] = int'(p);
      k = (k + 1) % (W * H);
      exp_valid = (rr >= 2) && (cc >= 2);
      exp_last  = exp_valid && (rr == H - 1) && (cc == W - 1);
      last_pix  = p;
      p9_known  = 1'b1;
      win_known = exp_valid;
      if (exp_valid) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[i*3+j] = 4'(img[rr-2+i][cc-2+j]);
      end
    end else begin
      exp_valid = 1'b0;
      exp_last  = 1'b0;
    end
    #1;
    chk("win_valid", {7'd0, win_valid}, {7'd0, exp_valid});
    chk("win_last", {7'd0, win_last}, {7'd0, exp_last});
    if (p9_known) chk("pixel9_latency", {4'd0, p9}, {4'd0, last_pix});
    if (win_known) begin
      for (int i = 0; i < 9; i++)
        chk($sformatf("pixel%0d", i + 1), {4'd0, obs[i]}, {4'd0, exp_win[i]});
    end
    if (win_valid === 1'b1) pulses++;
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_in = 4'd0;
    win_known = 1'b0; p9_known = 1'b0; last_pix = 4'd0; k = 0;
    exp_valid = 1'b0; exp_last = 1'b0;
    for (int i = 0; i < 9; i++) exp_win[i] = 4'd0;

    // Reset, with pix_valid asserted on the second cycle to exercise priority
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd9);

    // Frame 1 with a 3-cycle bubble between n=10 and n=11
    pulses = 0;
    for (int n = 0; n <= 10; n++) step(1'b0, 1'b1, 4'(n % 16));
    for (int b = 0; b < 3; b++) step(1'b0, 1'b0, 4'(b + 3));
    for (int n = 11; n <= 15; n++) step(1'b0, 1'b1, 4'(n % 16));
    chk("pulses_frame1", 8'(pulses), 8'd4);

    // Frame 2 streamed back to back
    pulses = 0;
    for (int n = 16; n <= 31; n++) step(1'b0, 1'b1, 4'(n % 16));
    chk("pulses_frame2", 8'(pulses), 8'd4);

    // Reset mid-frame after n=7, then a fresh frame
    for (int n = 0; n <= 7; n++) step(1'b0, 1'b1, 4'(n % 16));
    step(1'b1, 1'b0, 4'd0);
    pulses = 0;
    for (int n = 0; n <= 15; n++) step(1'b0, 1'b1, 4'(n % 16));
    chk("pulses_after_reset", 8'(pulses), 8'd4);

    // Random pixels, random bubbles and occasional resets
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
           4'($urandom_range(15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
